uart_tx_queue: RTL and testbench

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_tx_queue_if.sv | 34 +++
 rtl/uart_tx_queue.sv | 109 ++++++++++
 tb/tb_uart_tx_queue.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_queue_if.sv
// Producer/transmitter signal bundle for uart_tx_queue; master is the
// producer + serial transmitter side, slave is the queue itself.
interface uart_tx_queue_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Handshake: a byte is taken on every rising edge where wr_en=1 and full=0;
  // a write seen while full=1 is dropped and raises the sticky overflow flag.
  // On the transmit side tx_start is a one-cycle pulse with tx_byte valid from
  // that edge; tx_idle=1 means the transmitter can accept a launch, it falls
  // the cycle after tx_start and rises again when the stop bit has gone out.
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          clr_overflow;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    tx_byte;
  logic          tx_start;
  logic          tx_idle;

  modport master (
    output wr_en, wr_data, flush, clr_overflow, tx_idle,
    input  full, empty, count, overflow, tx_byte, tx_start
  );

  modport slave (
    input  wr_en, wr_data, flush, clr_overflow, tx_idle,
    output full, empty, count, overflow, tx_byte, tx_start
  );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter: circular buffer plus a three-state
// launch FSM that pops one byte per transmitter idle period.
module uart_tx_queue #(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_queue_if.slave   bus,
  output logic [1:0]       o_dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_overflow;
  logic [7:0]    r_tx_byte;
  logic          r_tx_start;

  logic          w_pop;
  logic          w_wr;
  logic          w_drop;
  logic [CW-1:0] w_count_nxt;

  // full is the registered flag, so a pop at the same edge cannot make room
  assign w_wr   = bus.wr_en && !r_full && !bus.flush;
  assign w_drop = bus.wr_en &&  r_full && !bus.flush;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_empty && bus.tx_idle) begin
          w_pop       = 1'b1;
          w_state_nxt = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!bus.tx_idle) w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (bus.tx_idle) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    if (bus.flush) w_count_nxt = '0;
    else           w_count_nxt = r_count + CW'(w_wr) - CW'(w_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_tx_byte  <= 8'h00;
      r_tx_start <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == CW'(DEPTH));
      r_empty    <= (w_count_nxt == '0);
      r_tx_start <= w_pop;
      if (w_pop) r_tx_byte <= r_mem[r_rptr];
      // a launch at a flush edge still takes the head; flush clears the rest
      if (bus.flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_wr)  r_wptr <= r_wptr + AW'(1);
        if (w_pop) r_rptr <= r_rptr + AW'(1);
      end
      if (w_drop)                r_overflow <= 1'b1;
      else if (bus.clr_overflow) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= bus.wr_data;
  end

  assign bus.full     = r_full;
  assign bus.empty    = r_empty;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;
  assign bus.tx_byte  = r_tx_byte;
  assign bus.tx_start = r_tx_start;
  assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: byte-order scoreboard, occupancy model and
// transmitter emulation, with one task per scenario.
module tb_uart_tx_queue;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  uart_tx_queue_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_launch = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // transmitter emulation or manual control of tx_idle
  logic xmtr_en   = 1'b1;
  logic x_idle    = 1'b1;
  logic x_busy    = 1'b0;
  logic man_idle  = 1'b1;
  int   xmtr_busy = 10;

  assign bus.tx_idle = xmtr_en ? x_idle : man_idle;

  always begin
    @(posedge clk);
    #1;
    if (xmtr_en && bus.tx_start) begin
      x_busy = 1'b1;
      x_idle = 1'b0;
      repeat (xmtr_busy) @(posedge clk);
      #1;
      x_idle = 1'b1;
      x_busy = 1'b0;
    end
  end

  // scoreboard and occupancy model
  logic [7:0] exp_q[$];
  int   m_cnt      = 0;
  logic m_ovf      = 1'b0;
  logic prev_start = 1'b0;
  logic [7:0] last_byte = 8'h00;
  int   ready_phase = 0; // 0 ready, 1 waiting for tx_idle low, 2 waiting for it high

  always @(posedge clk) begin
    logic       p_rst, p_wr, p_fl, p_clr, p_idle, acc, drop, launch_ok;
    logic [7:0] p_data, exp_b;
    int         cnt_pre;
    p_rst  = rst_n;
    p_wr   = bus.wr_en;
    p_data = bus.wr_data;
    p_fl   = bus.flush;
    p_clr  = bus.clr_overflow;
    p_idle = bus.tx_idle;
    #1;
    if (!p_rst || !rst_n) begin
      exp_q.delete();
      m_cnt = 0; m_ovf = 1'b0; prev_start = 1'b0;
      last_byte = 8'h00; ready_phase = 0;
    end else begin
      cnt_pre = m_cnt;
      if (bus.tx_start) begin
        n_launch++;
        launch_ok = p_idle && (cnt_pre > 0) && !prev_start && (ready_phase == 0);
        n_checks++;
        if (!launch_ok) begin
          n_errors++;
          $display("FAIL launch_legal: t=%0t tx_idle=%0b held=%0d prev_start=%0b phase=%0d",
                   $time, p_idle, cnt_pre, prev_start, ready_phase);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL tx_byte_order: t=%0t got %02h with nothing expected", $time, bus.tx_byte);
        end else begin
          exp_b = exp_q.pop_front();
          if (bus.tx_byte !== exp_b) begin
            n_errors++;
            $display("FAIL tx_byte_order: t=%0t got %02h expected %02h", $time, bus.tx_byte, exp_b);
          end
        end
        last_byte   = bus.tx_byte;
        ready_phase = 1;
      end else begin
        n_checks++;
        if (bus.tx_byte !== last_byte) begin
          n_errors++;
          $display("FAIL tx_byte_hold: t=%0t got %02h expected %02h", $time, bus.tx_byte, last_byte);
        end
        if (ready_phase == 1 && !p_idle)     ready_phase = 2;
        else if (ready_phase == 2 && p_idle) ready_phase = 0;
      end
      acc  = p_wr && !p_fl && (cnt_pre < DEPTH);
      drop = p_wr && !p_fl && (cnt_pre == DEPTH);
      if (p_fl) exp_q.delete();
      else if (acc) exp_q.push_back(p_data);
      m_cnt = exp_q.size();
      if (drop)       m_ovf = 1'b1;
      else if (p_clr) m_ovf = 1'b0;
      n_checks++;
      if (bus.count !== CW'(m_cnt) || bus.full !== (m_cnt == DEPTH) ||
          bus.empty !== (m_cnt == 0) || bus.overflow !== m_ovf) begin
        n_errors++;
        $display("FAIL occupancy: t=%0t count=%0d full=%0b empty=%0b ovf=%0b expected count=%0d ovf=%0b",
                 $time, bus.count, bus.full, bus.empty, bus.overflow, m_cnt, m_ovf);
      end
      prev_start = bus.tx_start;
    end
  end

  // driver tasks
  task automatic drive_write(input logic [7:0] d);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
  endtask

  task automatic stop_write();
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !x_busy && bus.tx_idle && !bus.tx_start) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.count !== '0 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.overflow !== 1'b0 ||
        bus.tx_start !== 1'b0 || bus.tx_byte !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_values: count=%0d empty=%0b full=%0b ovf=%0b start=%0b byte=%02h",
               bus.count, bus.empty, bus.full, bus.overflow, bus.tx_start, bus.tx_byte);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    drive_write(8'hA5);
    stop_write();
    @(posedge clk); #1;
    n_checks++;
    if (bus.tx_start !== 1'b1 || bus.tx_byte !== 8'hA5) begin
      n_errors++;
      $display("FAIL single_latency: start=%0b byte=%02h expected start=1 byte=a5", bus.tx_start, bus.tx_byte);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.tx_start !== 1'b0 || bus.count !== '0) begin
      n_errors++;
      $display("FAIL single_pulse: start=%0b count=%0d expected 0 and 0", bus.tx_start, bus.count);
    end
    wait_drain(ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL single_drain: timeout got 0 expected 1"); end
  endtask

  task automatic test_fill_overflow();
    bit ok;
    @(negedge clk); xmtr_en = 1'b0; man_idle = 1'b0;
    for (int i = 0; i < DEPTH; i++) drive_write(8'(i));
    drive_write(8'h5A);
    stop_write();
    n_checks++;
    if (bus.full !== 1'b1 || bus.count !== CW'(DEPTH) || bus.overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL fill_overflow: full=%0b count=%0d ovf=%0b expected 1 %0d 1", bus.full, bus.count, bus.overflow, DEPTH);
    end
    bus.clr_overflow = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h77;
    @(negedge clk); bus.clr_overflow = 1'b0; bus.wr_en = 1'b0;
    n_checks++;
    if (bus.overflow !== 1'b1) begin n_errors++; $display("FAIL clr_vs_drop: ovf=%0b expected 1", bus.overflow); end
    bus.clr_overflow = 1'b1;
    @(negedge clk); bus.clr_overflow = 1'b0;
    n_checks++;
    if (bus.overflow !== 1'b0) begin n_errors++; $display("FAIL clr_overflow: ovf=%0b expected 0", bus.overflow); end
    xmtr_en = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'hEE;
    @(negedge clk); bus.wr_en = 1'b0;
    n_checks++;
    if (bus.overflow !== 1'b1 || bus.count !== CW'(DEPTH - 1) || bus.tx_start !== 1'b1 || bus.tx_byte !== 8'h00) begin
      n_errors++;
      $display("FAIL full_write_pop: ovf=%0b count=%0d start=%0b byte=%02h expected 1 %0d 1 00",
               bus.overflow, bus.count, bus.tx_start, bus.tx_byte, DEPTH - 1);
    end
    wait_drain(ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL fill_drain: timeout got 0 expected 1"); end
    bus.clr_overflow = 1'b1;
    @(negedge clk); bus.clr_overflow = 1'b0;
  endtask

  task automatic test_three_bytes();
    bit ok;
    int base = n_launch;
    for (int i = 0; i < 3; i++) drive_write(8'($urandom_range(0, 255)));
    stop_write();
    wait_drain(ok);
    n_checks++;
    if (!ok || n_launch - base != 3) begin
      n_errors++;
      $display("FAIL three_bytes: launches=%0d drained=%0b expected 3 and 1", n_launch - base, ok);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int base = n_launch;
    int sent = 0;
    xmtr_busy = 3;
    while (sent < 20) begin
      int burst = $urandom_range(1, 6);
      if (burst > 20 - sent) burst = 20 - sent;
      for (int i = 0; i < burst; i++) drive_write(8'($urandom_range(0, 255)));
      stop_write();
      sent += burst;
      repeat ($urandom_range(5, 15)) @(negedge clk);
    end
    wait_drain(ok);
    n_checks++;
    if (!ok || n_launch - base != 20 || bus.overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_stream: launches=%0d drained=%0b ovf=%0b expected 20 1 0", n_launch - base, ok, bus.overflow);
    end
    xmtr_busy = 10;
  endtask

  task automatic test_flush();
    bit ok;
    int base;
    for (int i = 0; i < 6; i++) drive_write(8'($urandom_range(0, 255)));
    stop_write();
    n_checks++;
    if (bus.count !== CW'(5) || bus.tx_idle !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_setup: count=%0d tx_idle=%0b expected 5 and 0", bus.count, bus.tx_idle);
    end
    bus.flush = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h99;
    @(negedge clk); bus.flush = 1'b0; bus.wr_en = 1'b0;
    n_checks++;
    if (bus.count !== '0 || bus.empty !== 1'b1 || bus.overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_clear: count=%0d empty=%0b ovf=%0b expected 0 1 0", bus.count, bus.empty, bus.overflow);
    end
    base = n_launch;
    wait_drain(ok);
    repeat (10) @(negedge clk);
    n_checks++;
    if (!ok || n_launch != base) begin
      n_errors++;
      $display("FAIL flush_no_launch: extra launches=%0d drained=%0b expected 0 and 1", n_launch - base, ok);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    @(negedge clk); xmtr_en = 1'b0; man_idle = 1'b0;
    for (int i = 0; i < 5; i++) drive_write(8'($urandom_range(0, 255)));
    stop_write();
    man_idle = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.tx_start !== 1'b1 || bus.count !== CW'(4)) begin
      n_errors++;
      $display("FAIL reset_mid_setup: start=%0b count=%0d expected 1 and 4", bus.tx_start, bus.count);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.count !== '0 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.overflow !== 1'b0 ||
        bus.tx_start !== 1'b0 || bus.tx_byte !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_async: count=%0d empty=%0b full=%0b ovf=%0b start=%0b byte=%02h",
               bus.count, bus.empty, bus.full, bus.overflow, bus.tx_start, bus.tx_byte);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    base = n_launch;
    repeat (10) @(negedge clk);
    n_checks++;
    if (n_launch != base) begin
      n_errors++;
      $display("FAIL reset_discard: launches=%0d expected 0", n_launch - base);
    end
    drive_write(8'hC3);
    stop_write();
    wait_drain(ok);
    n_checks++;
    if (!ok || n_launch != base + 1) begin
      n_errors++;
      $display("FAIL reset_relaunch: launches=%0d drained=%0b expected 1 and 1", n_launch - base, ok);
    end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.flush = 1'b0; bus.clr_overflow = 1'b0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_three_bytes();
    test_wrap();
    test_flush();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL final_queue: %0d bytes still expected, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
